// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard sequencer: FSM state codes and register constants.
// Pure definitions; no logic, no timing.
package hazard_pkg;

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_LOAD_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH      = 2'd2;
  localparam logic [1:0] ST_HILO_WAIT  = 2'd3;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hilo_busy_counter.sv
// Loadable saturating down-counter tracking how long HI/LO stay busy after a mult/div.
// Load wins over decrement; busy is high whenever the count is non-zero.
module hilo_busy_counter #(
  parameter int W = 3
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         busy_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use, HI/LO and taken-branch hazards.
// Mealy outputs act on a hazard in the cycle it is seen; multi-cycle holds are sequenced by the FSM.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int IDEX_DEPTH    = 2,
  parameter int FLUSH_CYCLES  = 2,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [4:0] IdRs,
  input  logic [4:0] IdRt,
  input  logic       IdUsesRs,
  input  logic       IdUsesRt,
  input  logic       IdReadHiLo,
  input  logic       IdMulDiv,
  input  logic       ExMemRead,
  input  logic [4:0] ExRt,
  input  logic       BranchTaken,
  output logic       PCWrite,
  output logic       IfIdWrite,
  output logic       IfIdFlush,
  output logic       IdExFlush,
  output logic       ExMemFlush,
  output logic [1:0] State
);

  localparam int SW   = $clog2(max_int(IDEX_DEPTH, FLUSH_CYCLES)) + 1;
  localparam int MD_W = $clog2(MULDIV_CYCLES) + 1;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic          load_haz;
  logic          hilo_haz;
  logic          md_busy;
  logic          md_load;

  assign load_haz = ExMemRead && (ExRt != REG_ZERO) &&
                    ((IdUsesRs && (ExRt == IdRs)) || (IdUsesRt && (ExRt == IdRt)));
  assign hilo_haz = IdReadHiLo && md_busy;

  // A taken branch squashes the mult/div in ID, so it must not mark HI/LO busy.
  assign md_load = IdMulDiv && IfIdWrite && !BranchTaken;

  hilo_busy_counter #(
    .W(MD_W)
  ) u_hilo_busy (
    .Clk    (Clk),
    .Rst    (Rst),
    .load_i (md_load),
    .value_i(MD_W'(MULDIV_CYCLES)),
    .busy_o (md_busy)
  );

  always_comb begin
    PCWrite    = 1'b1;
    IfIdWrite  = 1'b1;
    IfIdFlush  = 1'b0;
    IdExFlush  = 1'b0;
    ExMemFlush = 1'b0;
    state_d    = state_q;
    scnt_d     = scnt_q;

    if (BranchTaken) begin
      IfIdFlush  = 1'b1;
      IdExFlush  = 1'b1;
      ExMemFlush = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = ST_FLUSH;
        scnt_d  = SW'(FLUSH_CYCLES - 2);
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      case (state_q)
        ST_LOAD_STALL: begin
          PCWrite   = 1'b0;
          IfIdWrite = 1'b0;
          IdExFlush = 1'b1;
          if (scnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            scnt_d = scnt_q - SW'(1);
          end
        end
        ST_FLUSH: begin
          IfIdFlush = 1'b1;
          IdExFlush = 1'b1;
          if (scnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            scnt_d = scnt_q - SW'(1);
          end
        end
        default: begin
          // RUN and HILO_WAIT share decode; HILO_WAIT just keeps stalling while HI/LO is busy.
          if (load_haz) begin
            PCWrite   = 1'b0;
            IfIdWrite = 1'b0;
            IdExFlush = 1'b1;
            if (IDEX_DEPTH > 1) begin
              state_d = ST_LOAD_STALL;
              scnt_d  = SW'(IDEX_DEPTH - 2);
            end else begin
              state_d = ST_RUN;
            end
          end else if (hilo_haz || ((state_q == ST_HILO_WAIT) && md_busy)) begin
            PCWrite   = 1'b0;
            IfIdWrite = 1'b0;
            IdExFlush = 1'b1;
            state_d   = ST_HILO_WAIT;
          end else begin
            state_d = ST_RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_RUN;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized bench for pipeline_hazard_ctrl against a cycle-count reference model.
module tb_pipeline_hazard_ctrl;

  localparam int IDEX = 2;
  localparam int FL   = 2;
  localparam int MD   = 4;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [4:0] IdRs, IdRt, ExRt;
  logic       IdUsesRs, IdUsesRt, IdReadHiLo, IdMulDiv, ExMemRead, BranchTaken;
  logic       PCWrite, IfIdWrite, IfIdFlush, IdExFlush, ExMemFlush;
  logic [1:0] State;

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding cycles owed to each kind of hold, plus HI/LO busy time.
  int m_stall_left, m_flush_left, m_busy;
  bit m_hilo;
  int n_stall_left, n_flush_left, n_busy;
  bit n_hilo;
  logic e_pc, e_ifw, e_iff, e_idf, e_emf;
  logic [1:0] e_st;

  pipeline_hazard_ctrl #(
    .IDEX_DEPTH(IDEX), .FLUSH_CYCLES(FL), .MULDIV_CYCLES(MD)
  ) dut (
    .Clk(Clk), .Rst(Rst), .IdRs(IdRs), .IdRt(IdRt), .IdUsesRs(IdUsesRs), .IdUsesRt(IdUsesRt),
    .IdReadHiLo(IdReadHiLo), .IdMulDiv(IdMulDiv), .ExMemRead(ExMemRead), .ExRt(ExRt),
    .BranchTaken(BranchTaken), .PCWrite(PCWrite), .IfIdWrite(IfIdWrite), .IfIdFlush(IfIdFlush),
    .IdExFlush(IdExFlush), .ExMemFlush(ExMemFlush), .State(State)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stall_left = 0;
    m_flush_left = 0;
    m_busy       = 0;
    m_hilo       = 1'b0;
  endtask

  task automatic model_eval();
    bit lh, hh;
    lh = ExMemRead && (ExRt != 5'd0) &&
         ((IdUsesRs && ExRt == IdRs) || (IdUsesRt && ExRt == IdRt));
    hh = IdReadHiLo && (m_busy > 0);
    if (m_stall_left > 0)      e_st = 2'd1;
    else if (m_flush_left > 0) e_st = 2'd2;
    else if (m_hilo)           e_st = 2'd3;
    else                       e_st = 2'd0;
    {e_pc, e_ifw, e_iff, e_idf, e_emf} = 5'b11000;
    n_stall_left = m_stall_left;
    n_flush_left = m_flush_left;
    n_hilo       = m_hilo;
    if (BranchTaken) begin
      {e_pc, e_ifw, e_iff, e_idf, e_emf} = 5'b11111;
      n_flush_left = FL - 1;
      n_stall_left = 0;
      n_hilo       = 1'b0;
    end else if (m_stall_left > 0) begin
      {e_pc, e_ifw, e_iff, e_idf, e_emf} = 5'b00010;
      n_stall_left = m_stall_left - 1;
    end else if (m_flush_left > 0) begin
      {e_pc, e_ifw, e_iff, e_idf, e_emf} = 5'b11110;
      n_flush_left = m_flush_left - 1;
    end else if (lh) begin
      {e_pc, e_ifw, e_iff, e_idf, e_emf} = 5'b00010;
      n_stall_left = IDEX - 1;
      n_hilo       = 1'b0;
    end else if (hh || (m_hilo && m_busy > 0)) begin
      {e_pc, e_ifw, e_iff, e_idf, e_emf} = 5'b00010;
      n_hilo = 1'b1;
    end else begin
      n_hilo = 1'b0;
    end
    if (IdMulDiv && e_ifw && !BranchTaken) n_busy = MD;
    else                                   n_busy = (m_busy > 0) ? m_busy - 1 : 0;
  endtask

  // Inputs are set by the caller just after a falling edge; check, then advance one cycle.
  task automatic step(input string tag);
    #1;
    model_eval();
    chk({tag, ".State"}, State, e_st);
    chk({tag, ".PCWrite"}, PCWrite, e_pc);
    chk({tag, ".IfIdWrite"}, IfIdWrite, e_ifw);
    chk({tag, ".IfIdFlush"}, IfIdFlush, e_iff);
    chk({tag, ".IdExFlush"}, IdExFlush, e_idf);
    chk({tag, ".ExMemFlush"}, ExMemFlush, e_emf);
    @(posedge Clk);
    m_stall_left = n_stall_left;
    m_flush_left = n_flush_left;
    m_busy       = n_busy;
    m_hilo       = n_hilo;
    @(negedge Clk);
  endtask

  task automatic idle();
    IdRs = 5'd0; IdRt = 5'd0; ExRt = 5'd0;
    IdUsesRs = 1'b0; IdUsesRt = 1'b0; IdReadHiLo = 1'b0; IdMulDiv = 1'b0;
    ExMemRead = 1'b0; BranchTaken = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] rt);
    idle();
    ExMemRead = 1'b1; ExRt = rt; IdRs = 5'd8; IdUsesRs = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".State"}, State, 2'd0);
    chk({tag, ".PCWrite"}, PCWrite, 1'b1);
    chk({tag, ".IfIdWrite"}, IfIdWrite, 1'b1);
    chk({tag, ".IfIdFlush"}, IfIdFlush, 1'b0);
    chk({tag, ".IdExFlush"}, IdExFlush, 1'b0);
    chk({tag, ".ExMemFlush"}, ExMemFlush, 1'b0);
  endtask

  initial begin
    Rst = 1'b0;
    idle();
    model_reset();
    #2;
    check_reset_outputs("reset_init");
    @(negedge Clk);
    Rst = 1'b1;

    // Load-use stall lasts IDEX_DEPTH cycles, then pass-through.
    load_use(5'd8);
    #1 chk("lu_c0_pc", PCWrite, 1'b0);
    step("lu_c0");
    idle();
    #1 chk("lu_c1_pc", PCWrite, 1'b0);
    step("lu_c1");
    #1 chk("lu_c2_pc", PCWrite, 1'b1);
    step("lu_c2");

    // Destination $zero never creates a hazard.
    load_use(5'd0);
    step("lu_zero");
    idle();
    step("lu_zero_after");

    // Taken branch: full flush, then one cycle without EX/MEM bubble, then RUN.
    BranchTaken = 1'b1;
    #1 chk("br_c0_emf", ExMemFlush, 1'b1);
    step("br_c0");
    idle();
    #1 chk("br_c1_emf", ExMemFlush, 1'b0);
    step("br_c1");
    step("br_c2");

    // HI/LO: mult issues, then mfhi waits until the busy window drains.
    IdMulDiv = 1'b1;
    step("hl_t0");
    idle();
    IdReadHiLo = 1'b1;
    for (int t = 1; t <= 7; t++) step($sformatf("hl_t%0d", t));
    idle();

    // Branch arriving in the second load-stall cycle wins and leaves no residual stall.
    load_use(5'd8);
    step("col_c0");
    idle();
    BranchTaken = 1'b1;
    step("col_c1");
    idle();
    #1 chk("col_c2_state", State, 2'd2);
    step("col_c2");
    step("col_c3");

    // Load hazard and branch together in RUN: branch takes priority.
    load_use(5'd8);
    BranchTaken = 1'b1;
    #1 chk("prio_pc", PCWrite, 1'b1);
    step("prio_c0");
    idle();
    step("prio_c1");
    step("prio_c2");

    // Asynchronous reset in the middle of a load stall abandons it immediately.
    load_use(5'd8);
    step("rst_pre");
    idle();
    #1 chk("rst_mid_state", State, 2'd1);
    Rst = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("reset_mid");
    @(negedge Clk);
    Rst = 1'b1;
    step("rst_post");

    for (int i = 0; i < 600; i++) begin
      IdRs        = 5'($urandom_range(0, 3));
      IdRt        = 5'($urandom_range(0, 3));
      ExRt        = 5'($urandom_range(0, 3));
      IdUsesRs    = 1'($urandom_range(0, 1));
      IdUsesRt    = 1'($urandom_range(0, 1));
      ExMemRead   = ($urandom_range(0, 2) == 0);
      IdReadHiLo  = ($urandom_range(0, 2) == 0);
      IdMulDiv    = ($urandom_range(0, 4) == 0);
      BranchTaken = ($urandom_range(0, 9) == 0);
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
